// File: rtl/fxp2float_s.sv
// Signed fixed-point (Q WOI.WOF) to IEEE-754 single converter, 3-stage valid/ready pipeline.
// Define FXP2FLOAT_RNE_EN for round-to-nearest-even on discarded bits; otherwise truncate.
module fxp2float_s #(
    parameter int WOI = 9,
    parameter int WOF = 7,
    localparam int W  = WOI + WOF,
    localparam int PW = $clog2(W)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] fxp_i,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [31:0]  fp32_o
);

    logic          v1_q, v2_q, v3_q;
    logic          rdy1, rdy2, rdy3;
    logic          s1_q, s2_q, z2_q;
    logic [W-1:0]  a1_d, a1_q, a2_q;
    logic [PW-1:0] p1_d, p2_q;
    logic          z1_d;
    logic [31:0]   fp_d, fp_q;

    // Backpressure ripples from the output towards the input in the same cycle.
    assign rdy3     = !v3_q || out_ready;
    assign rdy2     = !v2_q || rdy3;
    assign rdy1     = !v1_q || rdy2;
    assign in_ready = rdy1;

    // The most negative input maps to 2^(W-1), which still fits unsigned in W bits.
    assign a1_d = fxp_i[W-1] ? (~fxp_i) + W'(1) : fxp_i;

    // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        p1_d = '0;
        for (int i = 0; i < W; i++) begin
            if (a1_q[i]) p1_d = PW'(i);
        end
        z1_d = (a1_q == '0);
    end

    logic [PW-1:0] sh;
    logic [W-1:0]  norm;
    logic [W+24:0] ext;
    logic [22:0]   frac, frac_r;
    logic [9:0]    exp_w;
    logic [7:0]    expo;
`ifdef FXP2FLOAT_RNE_EN
    logic          guard, sticky, rnd_up, carry;
`endif

    always_comb begin
        sh     = PW'(W - 1) - p2_q;
        norm   = a2_q << sh;
        ext    = {norm, 25'b0};
        frac   = ext[W+23:W+1];
        exp_w  = 10'(p2_q) + 10'd127 - 10'(WOF);
`ifdef FXP2FLOAT_RNE_EN
        guard  = ext[W];
        sticky = |ext[W-1:0];
        rnd_up = guard && (sticky || frac[0]);
        {carry, frac_r} = {1'b0, frac} + 24'(rnd_up);
        expo   = exp_w[7:0] + 8'(carry);
`else
        frac_r = frac;
        expo   = exp_w[7:0];
`endif
        fp_d   = z2_q ? 32'h0 : {s2_q, expo, frac_r};
    end

    // Bits below the 23-bit fraction only matter when rounding is enabled.
    logic unused_ok;
    assign unused_ok = ^{exp_w[9:8], ext[W:0]};

    // NOTE: sequential state uses non-blocking assignments so all stages update from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: data registers are reset too, so fp32_o reads 0 straight out of reset.
            v1_q <= 1'b0;
            v2_q <= 1'b0;
            v3_q <= 1'b0;
            s1_q <= 1'b0;
            a1_q <= '0;
            s2_q <= 1'b0;
            z2_q <= 1'b0;
            a2_q <= '0;
            p2_q <= '0;
            fp_q <= 32'h0;
        end else begin
            if (rdy1) begin
                v1_q <= in_valid;
                if (in_valid) begin
                    s1_q <= fxp_i[W-1];
                    a1_q <= a1_d;
                end
            end
            if (rdy2) begin
                v2_q <= v1_q;
                if (v1_q) begin
                    s2_q <= s1_q;
                    a2_q <= a1_q;
                    p2_q <= p1_d;
                    z2_q <= z1_d;
                end
            end
            if (rdy3) begin
                v3_q <= v2_q;
                if (v2_q) fp_q <= fp_d;
            end
        end
    end

    assign out_valid = v3_q;
    assign fp32_o    = fp_q;

endmodule

// File: tb/tb_fxp2float_s.sv
// Self-checking bench for fxp2float_s: default (Q9.7) and wide (Q24.8) instances against a real-arithmetic model.
module tb_fxp2float_s;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    always #5 clk = ~clk;

    logic        in_valid_a = 1'b0, in_ready_a, out_valid_a, out_ready_a = 1'b1;
    logic [15:0] fxp_a = '0;
    logic [31:0] fp_a;

    logic        in_valid_b = 1'b0, in_ready_b, out_valid_b, out_ready_b = 1'b1;
    logic [31:0] fxp_b = '0;
    logic [31:0] fp_b;

    fxp2float_s #(.WOI(9), .WOF(7)) u_dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid_a), .in_ready(in_ready_a), .fxp_i(fxp_a),
        .out_valid(out_valid_a), .out_ready(out_ready_a), .fp32_o(fp_a)
    );

    fxp2float_s #(.WOI(24), .WOF(8)) u_wide (
        .clk(clk), .rst(rst),
        .in_valid(in_valid_b), .in_ready(in_ready_b), .fxp_i(fxp_b),
        .out_valid(out_valid_b), .out_ready(out_ready_b), .fp32_o(fp_b)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Value v / 2^wof converted with real arithmetic, then rounded or truncated to 23 fraction bits.
    function automatic logic [31:0] model(input longint v, input int wof);
        real    y, f, rem;
        int     e;
        longint fi;
        logic   s;
        if (v == 0) return 32'h0;
        s = (v < 0);
        y = s ? -real'(v) : real'(v);
        e = -wof;
        while (y >= 2.0) begin y = y / 2.0; e++; end
        while (y < 1.0)  begin y = y * 2.0; e--; end
        f   = (y - 1.0) * 8388608.0;
        fi  = longint'($floor(f));
        rem = f - real'(fi);
`ifdef FXP2FLOAT_RNE_EN
        if (rem > 0.5 || (rem == 0.5 && fi[0])) fi++;
        if (fi == 64'd8388608) begin fi = 0; e++; end
`else
        if (rem < 0.0) fi = 0;
`endif
        return {s, 8'(e + 127), 23'(fi)};
    endfunction

    // Scoreboards: expected results queued on input transfer, popped on output transfer.
    logic [31:0] q_a[$];
    logic [31:0] q_b[$];
    logic        hold_pend = 1'b0;
    logic [31:0] held = '0;
    logic        took_a = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            q_a.delete();
            q_b.delete();
            hold_pend = 1'b0;
            took_a    = 1'b0;
        end else begin
            if (hold_pend) begin
                check("hold_valid", 32'(out_valid_a), 32'd1);
                check("hold_data", fp_a, held);
            end
            hold_pend = out_valid_a && !out_ready_a;
            held      = fp_a;
            took_a    = in_valid_a && in_ready_a;
            if (took_a) q_a.push_back(model(longint'($signed(fxp_a)), 7));
            if (out_valid_a && out_ready_a) begin
                if (q_a.size() == 0) check("out_unexpected_a", 32'(q_a.size()), 32'd1);
                else check("fp_a", fp_a, q_a.pop_front());
            end
            if (in_valid_b && in_ready_b) q_b.push_back(model(longint'($signed(fxp_b)), 8));
            if (out_valid_b && out_ready_b) begin
                if (q_b.size() == 0) check("out_unexpected_b", 32'(q_b.size()), 32'd1);
                else check("fp_b", fp_b, q_b.pop_front());
            end
        end
    end

    task automatic directed_a(input logic [15:0] x, input logic [31:0] exp);
        @(posedge clk); #1; in_valid_a = 1'b1; fxp_a = x; out_ready_a = 1'b1;
        @(posedge clk); #1; in_valid_a = 1'b0;
        @(posedge clk); #1; check("lat_early_a", 32'(out_valid_a), 32'd0);
        @(posedge clk); #1; check("lat_valid_a", 32'(out_valid_a), 32'd1);
        check("const_a", fp_a, exp);
    endtask

    task automatic directed_b(input logic [31:0] x, input logic [31:0] exp);
        @(posedge clk); #1; in_valid_b = 1'b1; fxp_b = x;
        @(posedge clk); #1; in_valid_b = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1; check("lat_valid_b", 32'(out_valid_b), 32'd1);
        check("const_b", fp_b, exp);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] burst_exp[8];
        int          sent, cyc;

        #12;
        check("rst_out_valid", 32'(out_valid_a), 32'd0);
        check("rst_fp", fp_a, 32'h0);
        @(posedge clk); #1; rst = 1'b0;
        check("rst_in_ready", 32'(in_ready_a), 32'd1);

        // Directed conversions at default parameters.
        directed_a(16'h0080, 32'h3F80_0000);
        directed_a(16'hFF80, 32'hBF80_0000);
        directed_a(16'h8000, 32'hC380_0000);
        directed_a(16'h7FFF, 32'h437F_FE00);
        directed_a(16'h0001, 32'h3C00_0000);
        directed_a(16'h0000, 32'h0000_0000);

        // Wide instance: discarded bits exercise rounding or truncation.
`ifdef FXP2FLOAT_RNE_EN
        directed_b(32'h7FFF_FFFF, 32'h4B00_0000);
`else
        directed_b(32'h7FFF_FFFF, 32'h4AFF_FFFF);
`endif

        // Back-to-back burst of 8: results on consecutive cycles, in order.
        @(posedge clk); #1;
        out_ready_a = 1'b1;
        for (int i = 0; i < 8; i++) begin
            logic [15:0] r;
            r = 16'($urandom);
            burst_exp[i] = model(longint'($signed(r)), 7);
            if (i == 0) begin in_valid_a = 1'b1; fxp_a = r; end
            else begin
                fxp_a = r;
            end
            if (i < 7) begin
                @(posedge clk); #1;
                if (i >= 2) begin
                    check("burst_valid", 32'(out_valid_a), 32'd1);
                    check("burst_data", fp_a, burst_exp[i-2]);
                end
            end
        end
        for (int k = 8; k <= 10; k++) begin
            @(posedge clk); #1;
            in_valid_a = 1'b0;
            check("burst_valid", 32'(out_valid_a), 32'd1);
            check("burst_data", fp_a, burst_exp[k-3]);
        end

        // Random stimulus with random backpressure.
        @(posedge clk); #1;
        in_valid_a = 1'b0;
        @(posedge clk); #1;
        sent = 0;
        cyc  = 0;
        while (sent < 1000 && cyc < 20000) begin
            @(posedge clk); #1;
            cyc++;
            if (took_a) sent++;
            out_ready_a = 1'($urandom_range(0, 1));
            if (!in_valid_a || took_a) begin
                in_valid_a = (sent < 1000) && ($urandom_range(0, 3) != 0);
                fxp_a      = 16'($urandom);
            end
        end
        in_valid_a  = 1'b0;
        out_ready_a = 1'b1;
        check("random_sent", 32'(sent), 32'd1000);
        for (int i = 0; i < 20 && (q_a.size() != 0 || out_valid_a); i++) @(posedge clk);
        #1;
        check("drain_a", 32'(q_a.size()), 32'd0);

        // Random wide samples, streaming every cycle.
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            in_valid_b = 1'b1;
            fxp_b      = $urandom;
        end
        @(posedge clk); #1;
        in_valid_b = 1'b0;
        for (int i = 0; i < 20 && (q_b.size() != 0 || out_valid_b); i++) @(posedge clk);
        #1;
        check("drain_b", 32'(q_b.size()), 32'd0);

        // Fill the pipeline under stall, then reset with 3 samples in flight.
        out_ready_a = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            in_valid_a = 1'b1;
            fxp_a      = 16'($urandom_range(1, 16'h7FFF));
        end
        @(posedge clk); #1;
        in_valid_a = 1'b0;
        check("full_in_ready", 32'(in_ready_a), 32'd0);
        check("full_out_valid", 32'(out_valid_a), 32'd1);
        rst = 1'b1;
        #1;
        check("midrst_out_valid", 32'(out_valid_a), 32'd0);
        check("midrst_fp", fp_a, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        out_ready_a = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            check("postrst_quiet", 32'(out_valid_a), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
